// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the operation encodings, the default datapath width and the helper
// that sizes the latency counter so it can hold the larger of the two latencies.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    localparam int MDU_DATA_W = 32;

    // Counter width: clog2(max(mult_lat, div_lat) + 1)
    function automatic int lat_cnt_w(input int mult_lat, input int div_lat);
        int max_lat;
        if (mult_lat > div_lat) begin
            max_lat = mult_lat;
        end else begin
            max_lat = div_lat;
        end
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// md_arith: combinational arithmetic core of the multiply/divide unit.
// Kept separate so the single-cycle * and / can later be swapped for an
// iterative implementation without touching the control logic.
// Ports:
//   op          in  2       operation (mdu_op_e encoding)
//   a, b        in  DATA_W  operand A (multiplicand/dividend), B (multiplier/divisor)
//   res_hi      out DATA_W  HI result (product upper half / remainder)
//   res_lo      out DATA_W  LO result (product lower half / quotient)
//   div_by_zero out 1       divide op with B == 0 (result must not commit)
module md_arith
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo,
    output logic              div_by_zero
);

    localparam int PW = 2 * DATA_W;
    localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};

    logic              is_signed_s;
    logic              b_zero_s;
    logic [PW-1:0]     a_ext_s;
    logic [PW-1:0]     b_ext_s;
    logic [PW-1:0]     prod_s;
    logic [DATA_W-1:0] a_mag_s;
    logic [DATA_W-1:0] b_mag_s;
    logic [DATA_W-1:0] div_b_s;
    logic [DATA_W-1:0] quot_u_s;
    logic [DATA_W-1:0] rem_u_s;
    logic [DATA_W-1:0] quot_s;
    logic [DATA_W-1:0] rem_s;

    // Product and quotient/remainder for the selected op.
    // Signed multiply uses sign extension to 2*DATA_W so an unsigned multiply
    // of the extended operands yields the exact two's-complement product.
    // Signed divide works on magnitudes, then restores signs: quotient negative
    // when operand signs differ, remainder takes the dividend's sign. The
    // most-negative / -1 case falls out as quotient = A, remainder = 0.
    always_comb begin
        is_signed_s = (op == MDU_MULT) || (op == MDU_DIV);
        b_zero_s    = (b == ZERO);

        a_ext_s = is_signed_s ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        b_ext_s = is_signed_s ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        prod_s  = a_ext_s * b_ext_s;

        a_mag_s  = (is_signed_s && a[DATA_W-1]) ? (~a + ONE) : a;
        b_mag_s  = (is_signed_s && b[DATA_W-1]) ? (~b + ONE) : b;
        // Keep the divider free of X when B is zero; the result is discarded.
        div_b_s  = b_zero_s ? ONE : b_mag_s;
        quot_u_s = a_mag_s / div_b_s;
        rem_u_s  = a_mag_s % div_b_s;

        quot_s = (is_signed_s && (a[DATA_W-1] ^ b[DATA_W-1])) ? (~quot_u_s + ONE) : quot_u_s;
        rem_s  = (is_signed_s && a[DATA_W-1]) ? (~rem_u_s + ONE) : rem_u_s;

        res_hi      = ZERO;
        res_lo      = ZERO;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                res_hi      = prod_s[PW-1:DATA_W];
                res_lo      = prod_s[DATA_W-1:0];
                div_by_zero = 1'b0;
            end
            MDU_DIV, MDU_DIVU: begin
                res_hi      = rem_s;
                res_lo      = quot_s;
                div_by_zero = b_zero_s;
            end
            default: begin
                res_hi      = ZERO;
                res_lo      = ZERO;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit.
// Accepts MULT/MULTU/DIV/DIVU when idle, holds busy for a fixed latency,
// then commits the result to HI/LO and pulses done. MTHI/MTLO writes are
// honoured only while idle and not launching an operation.
// Ports:
//   clk      in  1       rising-edge clock
//   reset    in  1       asynchronous active-low reset
//   start    in  1       launch op (accepted only when busy == 0)
//   op       in  2       0=MULT 1=MULTU 2=DIV 3=DIVU
//   rs_data  in  DATA_W  operand A
//   rt_data  in  DATA_W  operand B
//   hi_we    in  1       MTHI write enable
//   lo_we    in  1       MTLO write enable
//   wdata    in  DATA_W  MTHI/MTLO data
//   busy     out 1       operation in flight
//   done     out 1       one-cycle pulse after HI/LO commit
//   hi, lo   out DATA_W  HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W   = MDU_DATA_W,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int              CNT_W    = lat_cnt_w(MULT_LAT, DIV_LAT);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] arith_hi_s;
    logic [DATA_W-1:0] arith_lo_s;
    logic              arith_dbz_s;
    logic              accept_s;
    logic              commit_s;
    logic              mt_ok_s;
    logic [CNT_W-1:0]  load_cnt_s;

    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] pend_hi_r;
    logic [DATA_W-1:0] pend_lo_r;
    logic              pend_dbz_r;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;

    md_arith #(
        .DATA_W (DATA_W)
    ) u_arith (
        .op          (op),
        .a           (rs_data),
        .b           (rt_data),
        .res_hi      (arith_hi_s),
        .res_lo      (arith_lo_s),
        .div_by_zero (arith_dbz_s)
    );

    // Accept / commit / write-permission decode.
    // Commit happens on the edge where the counter steps from 1 to 0.
    always_comb begin
        accept_s   = start && !busy_r;
        commit_s   = busy_r && (cnt_r == CNT_ONE);
        mt_ok_s    = !busy_r && !start;
        // op[1] set selects the divide latency (DIV/DIVU).
        load_cnt_s = op[1] ? DIV_CNT : MULT_CNT;
    end

    // Latency counter, busy and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= commit_s;
            if (accept_s) begin
                cnt_r  <= load_cnt_s;
                busy_r <= 1'b1;
            end else if (busy_r) begin
                cnt_r  <= cnt_r - CNT_ONE;
                busy_r <= !commit_s;
            end else begin
                cnt_r  <= cnt_r;
                busy_r <= busy_r;
            end
        end
    end

    // Pending result captured at accept; the operands are not needed afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_hi_r  <= {DATA_W{1'b0}};
            pend_lo_r  <= {DATA_W{1'b0}};
            pend_dbz_r <= 1'b0;
        end else if (accept_s) begin
            pend_hi_r  <= arith_hi_s;
            pend_lo_r  <= arith_lo_s;
            pend_dbz_r <= arith_dbz_s;
        end else begin
            pend_hi_r  <= pend_hi_r;
            pend_lo_r  <= pend_lo_r;
            pend_dbz_r <= pend_dbz_r;
        end
    end

    // HI/LO registers: result commit (skipped on divide-by-zero) or MTHI/MTLO.
    // Commit and MT writes cannot coincide since commit requires busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else if (commit_s && !pend_dbz_r) begin
            hi_r <= pend_hi_r;
            lo_r <= pend_lo_r;
        end else begin
            hi_r <= (hi_we && mt_ok_s) ? wdata : hi_r;
            lo_r <= (lo_we && mt_ok_s) ? wdata : lo_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (DATA_W=32, MULT_LAT=5, DIV_LAT=10).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MLAT = 5;
    localparam int DLAT = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(
        .DATA_W   (32),
        .MULT_LAT (MLAT),
        .DIV_LAT  (DLAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present op for one cycle; returns at the falling edge after the accept edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Count remaining busy cycles (bounded), then expect the done pulse.
    task automatic run_to_done(input int lat, input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 32'(n), 32'(lat));
        chk({tag, " done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int seen_done;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = 32'd0;

        // 1. Reset state, then reset in the middle of a DIVU
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);

        launch(MDU_DIVU, 32'd100, 32'd3);
        chk("middiv busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("middiv busy drop", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1;
        end
        chk("middiv no done", 32'(seen_done), 32'd0);
        chk("middiv hi", hi, 32'd0);
        chk("middiv lo", lo, 32'd0);

        // 2. MULT / MULTU of -2 * 3
        launch(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        run_to_done(MLAT, "mult");
        chk("mult hi", hi, 32'hFFFF_FFFF);
        chk("mult lo", lo, 32'hFFFF_FFFA);
        @(negedge clk);
        chk("mult done pulse end", {31'd0, done}, 32'd0);

        launch(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_to_done(MLAT, "multu");
        chk("multu hi", hi, 32'h0000_0002);
        chk("multu lo", lo, 32'hFFFF_FFFA);

        // 3. DIV -7/2 and DIVU 7/2
        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_to_done(DLAT, "div");
        chk("div lo", lo, 32'hFFFF_FFFD);
        chk("div hi", hi, 32'hFFFF_FFFF);

        launch(MDU_DIVU, 32'd7, 32'd2);
        run_to_done(DLAT, "divu");
        chk("divu lo", lo, 32'd3);
        chk("divu hi", hi, 32'd1);

        // 4. Signed overflow and divide by zero
        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_to_done(DLAT, "divovf");
        chk("divovf lo", lo, 32'h8000_0000);
        chk("divovf hi", hi, 32'h0000_0000);

        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h11;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h22;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);
        launch(MDU_DIVU, 32'd5, 32'd0);
        run_to_done(DLAT, "div0");
        chk("div0 hi", hi, 32'h11);
        chk("div0 lo", lo, 32'h22);

        // 5. Start and MTLO during MULT are ignored; back-to-back start in done cycle
        @(negedge clk);
        launch(MDU_MULT, 32'd5, 32'd6);
        $display("note: deliberate protocol error, start DIV and lo_we while busy");
        op      = MDU_DIV;
        rs_data = 32'd100;
        rt_data = 32'd7;
        start   = 1'b1;
        lo_we   = 1'b1;
        wdata   = 32'h55;
        @(negedge clk);
        start   = 1'b0;
        lo_we   = 1'b0;
        chk("busy mtlo dropped", lo, 32'h22);
        // one busy cycle already elapsed before the ignored requests
        run_to_done(MLAT - 1, "mult_ign");
        chk("mult_ign lo", lo, 32'd30);
        chk("mult_ign hi", hi, 32'd0);
        launch(MDU_MULTU, 32'd7, 32'd8);
        chk("b2b busy no gap", {31'd0, busy}, 32'd1);
        run_to_done(MLAT, "b2b");
        chk("b2b lo", lo, 32'd56);

        // 6. Idle MTHI+MTLO together; start+hi_we in same cycle
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFE_BABE;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mt both hi", hi, 32'hCAFE_BABE);
        chk("mt both lo", lo, 32'hCAFE_BABE);
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        launch(MDU_MULTU, 32'd2, 32'd3);
        hi_we = 1'b0;
        chk("start+hi_we hi held", hi, 32'hCAFE_BABE);
        run_to_done(MLAT, "start_hiwe");
        chk("start+hi_we hi", hi, 32'd0);
        chk("start+hi_we lo", lo, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
